// File: rtl/button_debouncer_pkg.sv
// ---------------------------------------------------------------------------
// button_debouncer_pkg : shared helpers for the push-button debouncer  (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

package button_debouncer_pkg;

  // Pad level seen when the button is not pressed.
  function automatic logic released_level(input int active_low);
    return (active_low != 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/button_debouncer_if.sv
// ---------------------------------------------------------------------------
// button_debouncer_if : raw pad inputs and conditioned button outputs  (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

interface button_debouncer_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] btn_raw;
  logic [WIDTH-1:0] btn_level;
  logic [WIDTH-1:0] btn_press;
  logic [WIDTH-1:0] btn_release;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release
  );

endinterface

`default_nettype wire

// File: rtl/button_debouncer_debounce_bit.sv
// ---------------------------------------------------------------------------
// debounce_bit : 2-flop synchroniser, stability counter, level and edge pulses  (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module debounce_bit
  import button_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 1
) (
  input  wire  clk,
  input  wire  reset,
  input  wire  raw,
  output logic level,
  output logic press,
  output logic release_pulse
);

  localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic           RELEASED = released_level(ACTIVE_LOW);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;
  logic             sample;

  // Normalised so that 1 always means pressed.
  assign sample = sync2 ^ RELEASED;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1         <= RELEASED;
      sync2         <= RELEASED;
      cnt           <= '0;
      level         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync1         <= raw;
      sync2         <= sync1;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      if (sample == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        // Pulses are registered alongside the level so they line up with it.
        level         <= sample;
        cnt           <= '0;
        press         <= sample;
        release_pulse <= ~sample;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/button_debouncer.sv
// ---------------------------------------------------------------------------
// button_debouncer : WIDTH independent debounced buttons for the input PIO  (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module button_debouncer #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 1
) (
  input  wire               clk,
  input  wire               reset,
  button_debouncer_if.slave btn
);

  logic [WIDTH-1:0] level_v;
  logic [WIDTH-1:0] press_v;
  logic [WIDTH-1:0] release_v;

  if (DEBOUNCE_CYCLES < 2) begin : g_param_check
    $error("button_debouncer: DEBOUNCE_CYCLES must be at least 2");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_bit (
      .clk           (clk),
      .reset         (reset),
      .raw           (btn.btn_raw[i]),
      .level         (level_v[i]),
      .press         (press_v[i]),
      .release_pulse (release_v[i])
    );
  end

  assign btn.btn_level   = level_v;
  assign btn.btn_press   = press_v;
  assign btn.btn_release = release_v;

endmodule

`default_nettype wire
